port_requester: RTL and testbench

Input-port request generator for the 5-port mesh router: the requesting end of the per-port req/grant interface into the output-port arbiter. It buffers incoming flits, decodes header/body/tail flit IDs, and presents `req`, `flit_id` and packet `length` to the arbiter. While granted it forwards one flit per cycle to the crossbar, and it keeps the request pending across a timeout-induced grant loss until the tail flit has left. One instance sits on each of the L, N, E, W and S inputs.

---
 rtl/noc_pkg.sv | 36 +++
 rtl/flit_fifo.sv | 66 ++++++
 rtl/port_requester.sv | 133 +++++++++++++
 tb/tb_port_requester.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router input ports: flit IDs, field positions, FSM encoding.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package noc_pkg;

    // Default flit width; the ID field always occupies the top ID_W bits of a flit.
    localparam int FLIT_W_DEF = 32;
    localparam int ID_W       = 3;
    localparam int ID_MSB     = FLIT_W_DEF - 1;
    localparam int ID_LSB     = FLIT_W_DEF - ID_W;

    // Packet length field, carried in the header flit only.
    localparam int LEN_MSB = 11;
    localparam int LEN_LSB = 0;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    // Flit IDs (one-hot); any other code is malformed.
    localparam logic [ID_W-1:0] FLIT_NONE   = 3'b000;
    localparam logic [ID_W-1:0] FLIT_HEADER = 3'b001;
    localparam logic [ID_W-1:0] FLIT_BODY   = 3'b010;
    localparam logic [ID_W-1:0] FLIT_TAIL   = 3'b100;

    // Requester FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    function automatic logic is_header(input logic [ID_W-1:0] id);
        return id == FLIT_HEADER;
    endfunction

    function automatic logic is_tail(input logic [ID_W-1:0] id);
        return id == FLIT_TAIL;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit buffer for one router input port: circular FIFO with show-ahead head output.
// Latency: a pushed flit is visible on head the cycle after the push.
// Backpressure: full blocks push even when a pop happens that cycle (no bypass); pop ignored when empty.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_dat  write request and data (dropped while full)
//   pop             read request (ignored while empty)
//   head            current FIFO head (valid only while !empty)
//   full, empty     occupancy flags
module flit_fifo #(
    parameter int DEPTH  = 8,
    parameter int FLIT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_dat,
    input  logic              pop,
    output logic [FLIT_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/port_requester.sv
// Input-port request generator: buffers flits, requests the output arbiter, forwards one flit per granted cycle.
// Latency: header push at t -> req at t+2; grant sampled at g -> out_flit valid at g+1.
// Backpressure: in_ready = !full; grant loss stalls forwarding with req held until the tail has left.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_flit, in_valid, in_ready  upstream link (push on in_valid && in_ready)
//   grant                      arbiter ownership bit for this port
//   req, flit_id, length       request, head flit ID (000 when empty), latched packet length
//   out_flit, out_valid        crossbar data
module port_requester
    import noc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int FLIT_W = FLIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              grant,
    output logic              req,
    output logic [ID_W-1:0]   flit_id,
    output logic [LEN_W-1:0]  length,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid
);

    logic [FLIT_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ID_W-1:0]   head_id;

    logic [1:0]        state_q,     state_d;
    logic              req_q,       req_d;
    logic              out_valid_q, out_valid_d;
    logic [FLIT_W-1:0] out_flit_q,  out_flit_d;
    logic [LEN_W-1:0]  length_q,    length_d;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign head_id   = fifo_head[FLIT_W-1 -: ID_W];
    // The head storage is stale when empty; report no flit to the arbiter.
    assign flit_id   = fifo_empty ? FLIT_NONE : head_id;

    flit_fifo #(
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (in_flit),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        length_d    = length_q;
        out_flit_d  = out_flit_q;
        out_valid_d = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (is_header(head_id)) begin
                        // Header stays in the FIFO; it is forwarded once granted.
                        length_d = fifo_head[LEN_MSB:LEN_LSB];
                        state_d  = ST_WAIT;
                    end else begin
                        // Orphan body/tail or malformed flit: drop it.
                        fifo_pop = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (grant && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    out_valid_d = 1'b1;
                    out_flit_d  = fifo_head;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                // No grant: hold position and keep requesting until re-granted.
                // Granted but empty: bubble, still requesting.
                if (grant && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    out_valid_d = 1'b1;
                    out_flit_d  = fifo_head;
                    if (is_tail(head_id)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered request follows the next state, so it drops the cycle after the tail pop.
        req_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            length_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            length_q    <= length_d;
        end
    end

    assign req       = req_q;
    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign length    = length_q;

endmodule

// File: tb/tb_port_requester.sv
// Directed bench for port_requester: basic packet, grant loss, orphans, FIFO full, back-to-back, reset mid-send.
// Latency: expected timings are hand-derived per cycle.
// Backpressure: exercised through grant = 0 and a full FIFO.
module tb_port_requester;
    import noc_pkg::*;

    localparam int DEPTH = 8;
    localparam int FW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_flit;
    logic          in_valid;
    logic          in_ready;
    logic          grant;
    logic          req;
    logic [2:0]    flit_id;
    logic [11:0]   length;
    logic [FW-1:0] out_flit;
    logic          out_valid;

    always #5 clk = ~clk;

    port_requester #(
        .DEPTH  (DEPTH),
        .FLIT_W (FW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .grant     (grant),
        .req       (req),
        .flit_id   (flit_id),
        .length    (length),
        .out_flit  (out_flit),
        .out_valid (out_valid)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [FW-1:0] got[$];
    logic [FW-1:0] exp_q[$];

    // Capture every forwarded flit mid-cycle.
    always @(negedge clk) begin
        if (out_valid) got.push_back(out_flit);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input logic [2:0] id, input logic [28:0] pl);
        return {id, pl};
    endfunction

    function automatic logic [FW-1:0] hdr(input logic [11:0] len);
        return mk(FLIT_HEADER, {17'd0, len});
    endfunction

    task automatic compare_q(input string tag);
        logic [FW-1:0] g;
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 'x;
            check(tag, g, exp_q[i]);
        end
    endtask

    // Bounded wait for req to fall, plus one cycle so the last flit is captured.
    task automatic wait_req_low(input string tag, input int budget);
        int n = 0;
        while (req && n < budget) begin
            tick();
            n++;
        end
        check(tag, req, 1'b0);
        tick();
    endtask

    logic [FW-1:0] f[8];
    logic [FW-1:0] p[6];
    logic          exp_req[9];

    initial begin
        rst      = 1'b1;
        in_flit  = '0;
        in_valid = 1'b0;
        grant    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req",       req,       1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_flit",  out_flit,  '0);
        check("rst_length",    length,    12'd0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_flit_id",   flit_id,   3'b000);
        rst = 1'b0;
        tick();

        // Basic packet, grant tied high
        grant = 1'b1;
        f[0] = hdr(12'd4);
        f[1] = mk(FLIT_BODY, 29'h0AA);
        f[2] = mk(FLIT_BODY, 29'h0BB);
        f[3] = mk(FLIT_TAIL, 29'h0CC);
        in_valid = 1'b1; in_flit = f[0];
        tick();                                   // header pushed
        check("b_flit_id_hdr", flit_id, FLIT_HEADER);
        check("b_req_t1",      req,     1'b0);
        in_flit = f[1];
        tick();                                   // WAIT, req up
        check("b_req_t2",   req,    1'b1);
        check("b_length",   length, 12'd4);
        in_flit = f[2];
        tick();                                   // header popped
        check("b_ov0",  out_valid, 1'b1);
        check("b_of0",  out_flit,  f[0]);
        in_flit = f[3];
        tick();
        check("b_ov1",  out_valid, 1'b1);
        check("b_of1",  out_flit,  f[1]);
        check("b_req_mid", req, 1'b1);
        in_valid = 1'b0;
        tick();
        check("b_ov2",  out_valid, 1'b1);
        check("b_of2",  out_flit,  f[2]);
        tick();                                   // tail popped
        check("b_ov3",  out_valid, 1'b1);
        check("b_of3",  out_flit,  f[3]);
        check("b_req_after_tail", req, 1'b0);
        tick();
        check("b_ov_idle", out_valid, 1'b0);

        // Grant loss mid-packet
        grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_flit = f[i];
            tick();
        end
        in_valid = 1'b0;
        got.delete();
        check("t_req_wait", req, 1'b1);
        grant = 1'b1;
        tick();
        tick();                                   // header and first body forwarded
        grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t_req_hold", req,       1'b1);
            check("t_len_hold", length,    12'd4);
            check("t_ov_stall", out_valid, 1'b0);
        end
        grant = 1'b1;
        wait_req_low("t_req_drop", 20);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(f[i]);
        compare_q("t_flits");

        // Orphan body and tail
        got.delete();
        in_valid = 1'b1; in_flit = mk(FLIT_BODY, 29'h111);
        tick();
        in_flit = mk(FLIT_TAIL, 29'h222);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("o_req", req,       1'b0);
            check("o_ov",  out_valid, 1'b0);
            tick();
        end
        check("o_flit_id", flit_id, 3'b000);
        check("o_none_out", got.size(), 0);

        // FIFO full with grant low
        grant = 1'b0;
        f[0] = hdr(12'd8);
        for (int i = 1; i < 7; i++) f[i] = mk(FLIT_BODY, 29'h100 + 29'(i));
        f[7] = mk(FLIT_TAIL, 29'h1FF);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_flit = f[i];
            if (i == 7) check("f_ready_before_8th", in_ready, 1'b1);
            tick();
        end
        check("f_ready_full", in_ready, 1'b0);
        in_flit = mk(FLIT_BODY, 29'h0DEAD);      // 9th flit offered
        tick();
        check("f_ready_still_full", in_ready, 1'b0);
        in_valid = 1'b0;
        grant = 1'b1;
        tick();                                   // first pop
        check("f_ready_after_pop", in_ready, 1'b1);
        wait_req_low("f_req_drop", 30);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
        compare_q("f_flits");
        check("f_empty_id", flit_id, 3'b000);

        // Back-to-back 3-flit packets, grant held high
        p[0] = hdr(12'd3);
        p[1] = mk(FLIT_BODY, 29'h301);
        p[2] = mk(FLIT_TAIL, 29'h302);
        p[3] = hdr(12'd3);
        p[4] = mk(FLIT_BODY, 29'h401);
        p[5] = mk(FLIT_TAIL, 29'h402);
        exp_req = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        got.delete();
        for (int i = 0; i < 9; i++) begin
            if (i < 6) begin
                in_valid = 1'b1; in_flit = p[i];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("bb_req", req, exp_req[i]);
            if (i == 0) check("bb_len_before", length, 12'd8);
            else        check("bb_len",        length, 12'd3);
        end
        tick();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(p[i]);
        compare_q("bb_flits");

        // Reset during the second forwarded flit
        f[0] = hdr(12'd4);
        f[1] = mk(FLIT_BODY, 29'h0AA);
        f[2] = mk(FLIT_BODY, 29'h0BB);
        f[3] = mk(FLIT_TAIL, 29'h0CC);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_flit = f[i];
            tick();
        end
        check("r_sending", out_valid, 1'b1);
        in_flit = f[3];
        rst = 1'b1;
        tick();
        check("r_req",       req,       1'b0);
        check("r_out_valid", out_valid, 1'b0);
        check("r_in_ready",  in_ready,  1'b1);
        check("r_flit_id",   flit_id,   3'b000);
        check("r_length",    length,    12'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("r_req_quiet", req,       1'b0);
        check("r_ov_quiet",  out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
